multi_port_pc_hazard_control: RTL and testbench
===============================================

Name: multi_port_pc_hazard_control

Overview:
- Next-generation PC-select and hazard unit for the single-cycle and short-pipeline cores.
- Generalised to NUM_DATA_PORTS data-memory ports, with a configurable post-redirect flush window.
- Adds a pending-redirect register, so control transfers that coincide with data stalls are deferred, not lost.
- Adds a stall watchdog. Sits between the fetch unit, decode/execute and the memory interfaces, and drives next_PC_sel/target_PC to the PC register.

Parameters:
- CORE, 0, core ID (debug only).
- ADDRESS_BITS, 20, PC/target width.
- NUM_DATA_PORTS, 2, number of data-memory ports checked for stalls (>=1).
- FLUSH_CYCLES, 2, cycles flush_fetch_receive stays high after a redirect (>=1).
- STALL_TIMEOUT, 1023, consecutive stall cycles before hazard_timeout asserts (>=1).

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- opcode_decode  in  7  opcode in decode
- opcode_execute  in  7  opcode in execute
- branch_execute  in  1  branch in execute is taken
- JALR_target_execute  in  ADDRESS_BITS  JALR target
- branch_target_execute  in  ADDRESS_BITS  branch target
- JAL_target_decode  in  ADDRESS_BITS  JAL target
- fetch_valid  in  1  instruction response valid
- issue_PC  in  ADDRESS_BITS  PC of the issued fetch
- fetch_address_in  in  ADDRESS_BITS  address of the returned instruction
- load_memory  in  NUM_DATA_PORTS  per-port load active
- store_memory  in  NUM_DATA_PORTS  per-port store active
- memory_valid  in  NUM_DATA_PORTS  per-port load data valid
- memory_ready  in  NUM_DATA_PORTS  per-port store accepted
- next_PC_sel  out  2  00 = PC+4, 01 = stall, 10 = target_PC
- target_PC  out  ADDRESS_BITS  redirect target
- flush_fetch_receive  out  1  discard the fetch response
- redirect_pending  out  1  a deferred redirect is held
- hazard_timeout  out  1  sticky stall-watchdog flag

Behaviour:
- Reset (async): state = RUN, pending cleared, flush counter = 0, stall counter = 0. While reset is high: next_PC_sel = 00, target_PC = 0, flush_fetch_receive = 0, redirect_pending = 0, hazard_timeout = 0.
- Hazard terms:
  - dmem_stall = OR over i of ((load_memory[i] & ~memory_valid[i]) | (store_memory[i] & ~memory_ready[i])).
  - if_stall = ~fetch_valid | (fetch_address_in != issue_PC).
- Redirect request (req), in priority order:
  - opcode_execute == JALR (1100111) -> JALR target.
  - opcode_execute == BRANCH (1100011) & branch_execute -> branch target.
  - opcode_decode == JAL (1101111) -> JAL target.
- Per-cycle output priority:
  1. dmem_stall: next_PC_sel = 01, target_PC = 0. Any req is captured into pending (pend_tgt, pend_from_exec). A new execute req overwrites a pending decode-sourced entry; all other reqs are ignored while pending is held.
  2. Pending held and no dmem_stall: next_PC_sel = 10, target_PC = pend_tgt. Pending clears next edge. Enter FLUSH.
  3. req: next_PC_sel = 10, target_PC = req target. Enter FLUSH.
  4. if_stall: next_PC_sel = 01, target_PC = 0.
  5. Otherwise: next_PC_sel = 00, target_PC = 0.
- flush_fetch_receive is asserted when:
  - the cycle is an if_stall in RUN (fetch_valid low or address mismatch), or
  - the cycle issues a redirect, or
  - the state is FLUSH.
- FSM:
  - RUN -> FLUSH on an issued redirect; the counter loads FLUSH_CYCLES-1.
  - FLUSH -> RUN when the counter is 0 and no new redirect is issued; otherwise decrement each cycle.
  - FLUSH_CYCLES = 1 means the flush lasts only the redirect cycle.
  - In FLUSH, decode-sourced JAL reqs are ignored (decode holds wrong-path data). Execute reqs are honoured and reload the counter.
- Watchdog: increments on each cycle with next_PC_sel == 01, clears on any other value, saturates at STALL_TIMEOUT. hazard_timeout sets when the count reaches STALL_TIMEOUT and holds until reset.
- Reset mid-FLUSH or with pending held: everything clears immediately, and no redirect is issued afterwards.

Optional Feature:
- HAZARD_PERF_COUNTERS_EN defined: adds 32-bit wrapping outputs if_stall_count, dmem_stall_count and redirect_count, zeroed on reset. Each increments on cycles where its cause determined next_PC_sel.
- Undefined: these ports are absent, with no counter logic.

Test Plan:
- Reset released, all inputs idle, fetch_valid = 1, issue_PC = fetch_address_in = 0 -> next_PC_sel = 00, target_PC = 0, flush = 0.
- fetch_address_in = 4, issue_PC = 0 -> next_PC_sel = 01, flush = 1. Restoring a match gives 00.
- load_memory = 2'b10, memory_valid = 2'b01 for 3 cycles with opcode_execute = JALR, target 4 -> 01 for 3 cycles with redirect_pending = 1. Next cycle gives 10 and target 4. flush = 1 for 2 cycles (FLUSH_CYCLES = 2).
- opcode_decode = JAL (target 12) and opcode_execute = BRANCH with branch_execute = 1 (target 8) together -> target 8. The JAL in the following FLUSH cycle is ignored.
- store_memory = 1, memory_ready = 0 held for STALL_TIMEOUT cycles -> hazard_timeout = 1, which stays 1 after the stall clears.
- Async reset asserted mid-FLUSH with pending held -> all outputs 0 immediately, with no redirect after release.

Source files
------------

// File: rtl/multi_port_pc_hazard_control.sv
// PC-select / hazard unit: picks PC+4, stall or redirect; defers redirects that collide with data stalls.
// Latency: next_PC_sel/target_PC/flush are combinational from inputs and state; pending/flush/watchdog state updates each clock.
// Backpressure: any data-port stall holds the PC (01) and parks a redirect in a one-entry pending register.
//
// Ports: clock/reset (async, active-high); decode/execute opcodes, branch outcome and JAL/JALR/branch targets;
// fetch response (fetch_valid, issue_PC, fetch_address_in); per-port load/store/valid/ready for NUM_DATA_PORTS ports;
// outputs next_PC_sel, target_PC, flush_fetch_receive, redirect_pending, hazard_timeout.
// Optional macro HAZARD_PERF_COUNTERS_EN adds if_stall_count, dmem_stall_count, redirect_count (32-bit, wrapping).
module multi_port_pc_hazard_control #(
    parameter int CORE           = 0,
    parameter int ADDRESS_BITS   = 20,
    parameter int NUM_DATA_PORTS = 2,
    parameter int FLUSH_CYCLES   = 2,
    parameter int STALL_TIMEOUT  = 1023
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [6:0]                opcode_decode,
    input  logic [6:0]                opcode_execute,
    input  logic                      branch_execute,
    input  logic [ADDRESS_BITS-1:0]   JALR_target_execute,
    input  logic [ADDRESS_BITS-1:0]   branch_target_execute,
    input  logic [ADDRESS_BITS-1:0]   JAL_target_decode,
    input  logic                      fetch_valid,
    input  logic [ADDRESS_BITS-1:0]   issue_PC,
    input  logic [ADDRESS_BITS-1:0]   fetch_address_in,
    input  logic [NUM_DATA_PORTS-1:0] load_memory,
    input  logic [NUM_DATA_PORTS-1:0] store_memory,
    input  logic [NUM_DATA_PORTS-1:0] memory_valid,
    input  logic [NUM_DATA_PORTS-1:0] memory_ready,
`ifdef HAZARD_PERF_COUNTERS_EN
    output logic [31:0]               if_stall_count,
    output logic [31:0]               dmem_stall_count,
    output logic [31:0]               redirect_count,
`endif
    output logic [1:0]                next_PC_sel,
    output logic [ADDRESS_BITS-1:0]   target_PC,
    output logic                      flush_fetch_receive,
    output logic                      redirect_pending,
    output logic                      hazard_timeout
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [1:0] SEL_PC4   = 2'b00;
    localparam logic [1:0] SEL_STALL = 2'b01;
    localparam logic [1:0] SEL_TGT   = 2'b10;
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam int SW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_TIMEOUT);

    // Elaboration-time sanity check on the configuration.
    if (CORE < 0 || NUM_DATA_PORTS < 1 || FLUSH_CYCLES < 1 || STALL_TIMEOUT < 1) begin : g_bad_params
        $error("multi_port_pc_hazard_control: illegal parameter value");
    end

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                  state, state_nxt;
    // In FLUSH, flush_cnt is the number of flush cycles left including the current one.
    logic [FW-1:0]           flush_cnt, flush_cnt_nxt;
    logic                    pend_vld, pend_vld_nxt;
    logic                    pend_from_exec, pend_from_exec_nxt;
    logic [ADDRESS_BITS-1:0] pend_tgt, pend_tgt_nxt;
    logic [SW-1:0]           stall_cnt, stall_cnt_nxt;
    logic                    timeout_flag;

    logic                    dmem_stall, if_stall;
    logic                    req_exec, req_dec, req;
    logic [ADDRESS_BITS-1:0] req_tgt;
    logic [1:0]              sel;
    logic [ADDRESS_BITS-1:0] tgt;
    logic                    redirect, flush;

    always_comb begin
        dmem_stall = |((load_memory & ~memory_valid) | (store_memory & ~memory_ready));
        if_stall   = ~fetch_valid | (fetch_address_in != issue_PC);

        req_exec = (opcode_execute == OP_JALR) | ((opcode_execute == OP_BRANCH) & branch_execute);
        // Decode is wrong-path while flushing, so its JAL is dropped in FLUSH.
        req_dec  = (opcode_decode == OP_JAL) & (state == RUN);
        req      = req_exec | req_dec;
        if (opcode_execute == OP_JALR) begin
            req_tgt = JALR_target_execute;
        end else if (req_exec) begin
            req_tgt = branch_target_execute;
        end else begin
            req_tgt = JAL_target_decode;
        end

        sel                = SEL_PC4;
        tgt                = '0;
        redirect           = 1'b0;
        pend_vld_nxt       = pend_vld;
        pend_from_exec_nxt = pend_from_exec;
        pend_tgt_nxt       = pend_tgt;

        if (dmem_stall) begin
            sel = SEL_STALL;
            // Empty slot takes any request; an execute request may replace a decode-sourced one.
            if ((!pend_vld && req) || (pend_vld && !pend_from_exec && req_exec)) begin
                pend_vld_nxt       = 1'b1;
                pend_from_exec_nxt = req_exec;
                pend_tgt_nxt       = req_tgt;
            end
        end else if (pend_vld) begin
            sel          = SEL_TGT;
            tgt          = pend_tgt;
            redirect     = 1'b1;
            pend_vld_nxt = 1'b0;
        end else if (req) begin
            sel      = SEL_TGT;
            tgt      = req_tgt;
            redirect = 1'b1;
        end else if (if_stall) begin
            sel = SEL_STALL;
        end

        flush = (if_stall && state == RUN) || redirect || (state == FLUSH);

        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        if (redirect) begin
            // The redirect cycle is itself the first flush cycle.
            flush_cnt_nxt = FW'(FLUSH_CYCLES - 1);
            state_nxt     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
        end else if (state == FLUSH) begin
            if (flush_cnt <= FW'(1)) begin
                flush_cnt_nxt = '0;
                state_nxt     = RUN;
            end else begin
                flush_cnt_nxt = flush_cnt - FW'(1);
            end
        end

        stall_cnt_nxt = '0;
        if (sel == SEL_STALL) begin
            stall_cnt_nxt = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + SW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= RUN;
            flush_cnt      <= '0;
            pend_vld       <= 1'b0;
            pend_from_exec <= 1'b0;
            pend_tgt       <= '0;
            stall_cnt      <= '0;
            timeout_flag   <= 1'b0;
        end else begin
            state          <= state_nxt;
            flush_cnt      <= flush_cnt_nxt;
            pend_vld       <= pend_vld_nxt;
            pend_from_exec <= pend_from_exec_nxt;
            pend_tgt       <= pend_tgt_nxt;
            stall_cnt      <= stall_cnt_nxt;
            if (stall_cnt_nxt == STALL_MAX) begin
                timeout_flag <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            if_stall_count   <= '0;
            dmem_stall_count <= '0;
            redirect_count   <= '0;
        end else begin
            if (dmem_stall) begin
                dmem_stall_count <= dmem_stall_count + 32'd1;
            end
            if (redirect) begin
                redirect_count <= redirect_count + 32'd1;
            end
            if (!dmem_stall && !redirect && if_stall) begin
                if_stall_count <= if_stall_count + 32'd1;
            end
        end
    end
`endif

    // Combinational outputs are forced low while reset is held, whatever the inputs do.
    assign next_PC_sel         = reset ? SEL_PC4 : sel;
    assign target_PC           = reset ? '0 : tgt;
    assign flush_fetch_receive = reset ? 1'b0 : flush;
    assign redirect_pending    = pend_vld;
    assign hazard_timeout      = timeout_flag;

endmodule

// File: tb/tb_multi_port_pc_hazard_control.sv
// Bench for multi_port_pc_hazard_control: a table of one-cycle vectors run back to back
// (state carries from row to row), then hand sequences for the watchdog and async reset.
module tb_multi_port_pc_hazard_control;

    localparam int AB = 20;
    localparam int NP = 2;
    localparam int TO = 1023;
    localparam logic [6:0] N = 7'h00;
    localparam logic [6:0] J = 7'b1101111;
    localparam logic [6:0] R = 7'b1100111;
    localparam logic [6:0] B = 7'b1100011;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode_decode, opcode_execute;
    logic          branch_execute;
    logic [AB-1:0] JALR_target_execute, branch_target_execute, JAL_target_decode;
    logic          fetch_valid;
    logic [AB-1:0] issue_PC, fetch_address_in;
    logic [NP-1:0] load_memory, store_memory, memory_valid, memory_ready;
    logic [1:0]    next_PC_sel;
    logic [AB-1:0] target_PC;
    logic          flush_fetch_receive, redirect_pending, hazard_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    multi_port_pc_hazard_control #(
        .CORE(0), .ADDRESS_BITS(AB), .NUM_DATA_PORTS(NP), .FLUSH_CYCLES(2), .STALL_TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset),
        .opcode_decode(opcode_decode), .opcode_execute(opcode_execute),
        .branch_execute(branch_execute),
        .JALR_target_execute(JALR_target_execute),
        .branch_target_execute(branch_target_execute),
        .JAL_target_decode(JAL_target_decode),
        .fetch_valid(fetch_valid), .issue_PC(issue_PC), .fetch_address_in(fetch_address_in),
        .load_memory(load_memory), .store_memory(store_memory),
        .memory_valid(memory_valid), .memory_ready(memory_ready),
        .next_PC_sel(next_PC_sel), .target_PC(target_PC),
        .flush_fetch_receive(flush_fetch_receive),
        .redirect_pending(redirect_pending), .hazard_timeout(hazard_timeout)
    );

    typedef struct {
        logic          fv;
        logic [AB-1:0] fa;
        logic [1:0]    ld, st, mv, mr;
        logic [6:0]    opd, ope;
        logic          br;
        logic [1:0]    sel;
        logic [AB-1:0] tgt;
        logic          fl, pend;
    } vec_t;

    vec_t tbl[27];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [AB-1:0] fa, input logic [1:0] ld,
                         input logic [1:0] st, input logic [1:0] mv, input logic [1:0] mr,
                         input logic [6:0] opd, input logic [6:0] ope, input logic br);
        fetch_valid      = fv;
        fetch_address_in = fa;
        load_memory      = ld;
        store_memory     = st;
        memory_valid     = mv;
        memory_ready     = mr;
        opcode_decode    = opd;
        opcode_execute   = ope;
        branch_execute   = br;
    endtask

    task automatic idle();
        drive(1'b1, '0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0);
    endtask

    initial begin
        // fv  fa  ld     st     mv     mr     opd ope br | sel   tgt fl pend
        tbl[0]  = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b0, 1'b0};
        tbl[1]  = '{1'b1, 20'd4, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b01, 20'd0,  1'b1, 1'b0};
        tbl[2]  = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b0, 1'b0};
        tbl[3]  = '{1'b1, 20'd0, 2'b10, 2'b00, 2'b01, 2'b00, N, R, 1'b0, 2'b01, 20'd0,  1'b0, 1'b0};
        tbl[4]  = '{1'b1, 20'd0, 2'b10, 2'b00, 2'b01, 2'b00, N, R, 1'b0, 2'b01, 20'd0,  1'b0, 1'b1};
        tbl[5]  = '{1'b1, 20'd0, 2'b10, 2'b00, 2'b01, 2'b00, N, R, 1'b0, 2'b01, 20'd0,  1'b0, 1'b1};
        tbl[6]  = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b10, 20'd4,  1'b1, 1'b1};
        tbl[7]  = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b1, 1'b0};
        tbl[8]  = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b0, 1'b0};
        tbl[9]  = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, J, B, 1'b1, 2'b10, 20'd8,  1'b1, 1'b0};
        tbl[10] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, J, N, 1'b0, 2'b00, 20'd0,  1'b1, 1'b0};
        tbl[11] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, J, N, 1'b0, 2'b10, 20'd12, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, R, 1'b0, 2'b10, 20'd4,  1'b1, 1'b0};
        tbl[13] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b1, 1'b0};
        tbl[14] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b0, 1'b0};
        tbl[15] = '{1'b0, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b01, 20'd0,  1'b1, 1'b0};
        tbl[16] = '{1'b1, 20'd0, 2'b00, 2'b01, 2'b00, 2'b00, J, N, 1'b0, 2'b01, 20'd0,  1'b0, 1'b0};
        tbl[17] = '{1'b1, 20'd0, 2'b00, 2'b01, 2'b00, 2'b00, N, B, 1'b1, 2'b01, 20'd0,  1'b0, 1'b1};
        tbl[18] = '{1'b1, 20'd0, 2'b00, 2'b01, 2'b00, 2'b00, N, R, 1'b0, 2'b01, 20'd0,  1'b0, 1'b1};
        tbl[19] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b10, 20'd8,  1'b1, 1'b1};
        tbl[20] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b1, 1'b0};
        tbl[21] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b0, 1'b0};
        tbl[22] = '{1'b1, 20'd4, 2'b00, 2'b00, 2'b00, 2'b00, J, N, 1'b0, 2'b10, 20'd12, 1'b1, 1'b0};
        tbl[23] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b1, 1'b0};
        tbl[24] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b0, 1'b0};
        tbl[25] = '{1'b0, 20'd0, 2'b01, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b01, 20'd0,  1'b1, 1'b0};
        tbl[26] = '{1'b1, 20'd0, 2'b00, 2'b00, 2'b00, 2'b00, N, N, 1'b0, 2'b00, 20'd0,  1'b0, 1'b0};

        JALR_target_execute   = 20'd4;
        branch_target_execute = 20'd8;
        JAL_target_decode     = 20'd12;
        issue_PC              = '0;
        idle();

        // Held in reset.
        #2;
        chk("rst sel", 32'(next_PC_sel), 32'd0);
        chk("rst tgt", 32'(target_PC), 32'd0);
        chk("rst flush", 32'(flush_fetch_receive), 32'd0);
        chk("rst pend", 32'(redirect_pending), 32'd0);
        chk("rst timeout", 32'(hazard_timeout), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 27; i++) begin
            drive(tbl[i].fv, tbl[i].fa, tbl[i].ld, tbl[i].st, tbl[i].mv, tbl[i].mr,
                  tbl[i].opd, tbl[i].ope, tbl[i].br);
            @(negedge clock);
            chk($sformatf("row%0d sel", i), 32'(next_PC_sel), 32'(tbl[i].sel));
            chk($sformatf("row%0d tgt", i), 32'(target_PC), 32'(tbl[i].tgt));
            chk($sformatf("row%0d flush", i), 32'(flush_fetch_receive), 32'(tbl[i].fl));
            chk($sformatf("row%0d pend", i), 32'(redirect_pending), 32'(tbl[i].pend));
            chk($sformatf("row%0d timeout", i), 32'(hazard_timeout), 32'd0);
            @(posedge clock);
            #1;
        end

        // Watchdog: a store stall held for STALL_TIMEOUT cycles.
        drive(1'b1, '0, 2'b00, 2'b01, 2'b00, 2'b00, N, N, 1'b0);
        for (int c = 1; c <= TO; c++) begin
            @(posedge clock);
            #1;
            if (c == TO - 1) chk("wd early", 32'(hazard_timeout), 32'd0);
        end
        chk("wd set", 32'(hazard_timeout), 32'd1);
        chk("wd sel", 32'(next_PC_sel), 32'd1);
        idle();
        @(posedge clock);
        #1;
        chk("wd sticky", 32'(hazard_timeout), 32'd1);
        chk("wd clear sel", 32'(next_PC_sel), 32'd0);

        // Reset asserted mid-FLUSH, with a stall and execute request on the inputs.
        drive(1'b1, '0, 2'b00, 2'b00, 2'b00, 2'b00, N, R, 1'b0);
        @(posedge clock);
        #1;
        drive(1'b1, '0, 2'b01, 2'b00, 2'b00, 2'b00, N, B, 1'b1);
        #1;
        chk("flush pre-rst", 32'(flush_fetch_receive), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst1 sel", 32'(next_PC_sel), 32'd0);
        chk("rst1 tgt", 32'(target_PC), 32'd0);
        chk("rst1 flush", 32'(flush_fetch_receive), 32'd0);
        chk("rst1 timeout", 32'(hazard_timeout), 32'd0);
        idle();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post rst1 sel", 32'(next_PC_sel), 32'd0);
        chk("post rst1 flush", 32'(flush_fetch_receive), 32'd0);

        // Reset asserted with a pending redirect held.
        @(posedge clock);
        #1;
        drive(1'b1, '0, 2'b01, 2'b00, 2'b00, 2'b00, N, R, 1'b0);
        @(posedge clock);
        #1;
        chk("pend pre-rst", 32'(redirect_pending), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst2 sel", 32'(next_PC_sel), 32'd0);
        chk("rst2 pend", 32'(redirect_pending), 32'd0);
        chk("rst2 flush", 32'(flush_fetch_receive), 32'd0);
        idle();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post rst2 sel", 32'(next_PC_sel), 32'd0);
        chk("post rst2 tgt", 32'(target_PC), 32'd0);
        @(negedge clock);
        chk("post rst2 sel2", 32'(next_PC_sel), 32'd0);
        chk("post rst2 pend", 32'(redirect_pending), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
